// File: rtl/eq_gain_ramp.sv
// Gain-ramp stage feeding the 8-band equalizer. Targets are written over a valid/ready port.
// Each sample tick starts a sweep that steps every band's working gain toward its target by at
// most STEP, one band per cycle. All bands are then committed to g_out in a single edge.
module eq_gain_ramp #(
  parameter int unsigned NUM_BANDS = 8,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned STEP      = 1,
  parameter int          GAIN_MIN  = -64,
  parameter int          GAIN_MAX  = 63
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [$clog2(NUM_BANDS)-1:0]     wr_band,
  input  logic signed [GAIN_W-1:0]         wr_gain,
  input  logic                             sample_tick,
  output logic signed [GAIN_W-1:0]         g_out [NUM_BANDS],
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned IdxW = $clog2(NUM_BANDS);
  localparam logic signed [GAIN_W-1:0] GainMin = GAIN_W'(GAIN_MIN);
  localparam logic signed [GAIN_W-1:0] GainMax = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W:0]   StepW   = (GAIN_W + 1)'(STEP);

  typedef enum logic [1:0] {StIdle, StSweep, StCommit} state_e;

  state_e                   state_q;
  logic [IdxW-1:0]          idx_q;
  logic signed [GAIN_W-1:0] target_q [NUM_BANDS];
  logic signed [GAIN_W-1:0] target_d [NUM_BANDS];
  logic signed [GAIN_W-1:0] work_q   [NUM_BANDS];
  logic                     done_q;

  logic                     wr_hit;
  logic signed [GAIN_W-1:0] wr_clamped;
  logic                     pending_d;
  logic                     mismatch_q;
  logic signed [GAIN_W:0]   tgt_w, wrk_w, diff, sum;
  logic signed [GAIN_W-1:0] work_next;

  // Handshake and status outputs; wr_ready is forced low while reset is asserted.
  always_comb begin
    wr_ready = rst_n && (state_q == StIdle);
    busy     = mismatch_q || (state_q != StIdle);
    done     = done_q;
  end

  // Clamp the written gain and form the post-write target set.
  always_comb begin
    wr_hit = wr_valid && wr_ready && (32'(wr_band) < NUM_BANDS);
    if (wr_gain < GainMin) begin
      wr_clamped = GainMin;
    end else if (wr_gain > GainMax) begin
      wr_clamped = GainMax;
    end else begin
      wr_clamped = wr_gain;
    end
    target_d = target_q;
    if (wr_hit) begin
      target_d[wr_band] = wr_clamped;
    end
  end

  // Outstanding-work flags: against the new targets (tick decision) and the current ones.
  always_comb begin
    pending_d  = 1'b0;
    mismatch_q = 1'b0;
    for (int i = 0; i < int'(NUM_BANDS); i++) begin
      if (target_d[i] != work_q[i]) pending_d = 1'b1;
      if (target_q[i] != work_q[i]) mismatch_q = 1'b1;
    end
  end

  // One bounded step of the band under the sweep index; never passes the target.
  always_comb begin
    tgt_w = {target_q[idx_q][GAIN_W-1], target_q[idx_q]};
    wrk_w = {work_q[idx_q][GAIN_W-1], work_q[idx_q]};
    diff  = tgt_w - wrk_w;
    if (diff > StepW) begin
      sum = wrk_w + StepW;
    end else if (diff < -StepW) begin
      sum = wrk_w - StepW;
    end else begin
      sum = tgt_w;
    end
    work_next = GAIN_W'(sum);
  end

  // Sweep/commit FSM with all state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_BANDS); i++) begin
        target_q[i] <= '0;
        work_q[i]   <= '0;
        g_out[i]    <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      target_q <= target_d;
      unique case (state_q)
        StIdle: begin
          if (sample_tick && pending_d) begin
            state_q <= StSweep;
            idx_q   <= '0;
          end
        end
        StSweep: begin
          work_q[idx_q] <= work_next;
          if (idx_q == IdxW'(NUM_BANDS - 1)) begin
            state_q <= StCommit;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StCommit: begin
          g_out   <= work_q;
          done_q  <= !mismatch_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_gain_ramp.sv
// Bench for eq_gain_ramp: two instances (STEP=1 and STEP=4) share one stimulus stream and are
// compared every cycle against a transaction-level model, plus directed ramp/stall/reset cases.
module tb_eq_gain_ramp;

  localparam int NB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, wr_valid, sample_tick;
  logic [2:0]        wr_band;
  logic signed [7:0] wr_gain;

  logic              rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
  logic signed [7:0] g_a [NB];
  logic signed [7:0] g_b [NB];

  eq_gain_ramp #(.NUM_BANDS(8), .GAIN_W(8), .STEP(1), .GAIN_MIN(-64), .GAIN_MAX(63)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_a), .wr_band(wr_band),
    .wr_gain(wr_gain), .sample_tick(sample_tick), .g_out(g_a), .busy(busy_a), .done(done_a)
  );

  eq_gain_ramp #(.NUM_BANDS(8), .GAIN_W(8), .STEP(4), .GAIN_MIN(-64), .GAIN_MAX(63)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_b), .wr_band(wr_band),
    .wr_gain(wr_gain), .sample_tick(sample_tick), .g_out(g_b), .busy(busy_b), .done(done_b)
  );

  int errors = 0;
  int checks = 0;

  // Model: per instance targets, working gains, committed gains, cycles left in a sweep.
  int m_tgt [2][NB];
  int m_wrk [2][NB];
  int m_g   [2][NB];
  int m_cnt [2];
  bit m_done [2];
  bit m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int step_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic int clampg(input int v);
    if (v < -64) return -64;
    if (v > 63) return 63;
    return v;
  endfunction

  function automatic bit differs(input int u);
    for (int b = 0; b < NB; b++) if (m_tgt[u][b] != m_wrk[u][b]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int g_of(input int u, input int b);
    return (u == 0) ? int'(g_a[b]) : int'(g_b[b]);
  endfunction

  // Advance the model by one clock edge using the inputs that edge will sample.
  task automatic advance();
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        for (int b = 0; b < NB; b++) begin
          m_tgt[u][b] = 0; m_wrk[u][b] = 0; m_g[u][b] = 0;
        end
        m_cnt[u]  = 0;
        m_done[u] = 1'b0;
      end else begin
        m_done[u] = 1'b0;
        if (m_cnt[u] == 0) begin
          if (wr_valid) m_tgt[u][wr_band] = clampg(int'(wr_gain));
          if (sample_tick && differs(u)) begin
            for (int b = 0; b < NB; b++) begin
              int d;
              d = m_tgt[u][b] - m_wrk[u][b];
              if (d > step_of(u)) m_wrk[u][b] += step_of(u);
              else if (d < -step_of(u)) m_wrk[u][b] -= step_of(u);
              else m_wrk[u][b] = m_tgt[u][b];
            end
            m_cnt[u] = NB + 1;
          end
        end else begin
          m_cnt[u]--;
          if (m_cnt[u] == 0) begin
            for (int b = 0; b < NB; b++) m_g[u][b] = m_wrk[u][b];
            m_done[u] = !differs(u);
          end
        end
      end
    end
    if (!rst_n) m_valid = 1'b1;
  endtask

  // One clock: compare outputs against the model mid-cycle, advance it, then pass the edge.
  task automatic cycle();
    @(negedge clk);
    if (m_valid) begin
      for (int u = 0; u < 2; u++) begin
        for (int b = 0; b < NB; b++) chk($sformatf("mon g%0d[%0d]", u, b), g_of(u, b), m_g[u][b]);
        chk($sformatf("mon ready%0d", u), int'(u == 0 ? rdy_a : rdy_b),
            int'(rst_n && m_cnt[u] == 0));
        chk($sformatf("mon busy%0d", u), int'(u == 0 ? busy_a : busy_b),
            int'(m_cnt[u] != 0 || differs(u)));
        chk($sformatf("mon done%0d", u), int'(u == 0 ? done_a : done_b), int'(m_done[u]));
      end
    end
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; sample_tick = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic write(input int band, input int gain);
    wr_valid = 1'b1; wr_band = 3'(band); wr_gain = 8'(gain);
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
  endtask

  typedef struct {
    int band;
    int gain;
    int exp_g;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1, 127, 63};  vecs[1] = '{2, -128, -64}; vecs[2] = '{3, 63, 63};
    vecs[3] = '{4, -64, -64}; vecs[4] = '{5, 64, 63};    vecs[5] = '{6, -65, -64};
    vecs[6] = '{7, 0, 0};     vecs[7] = '{0, -1, -1};    vecs[8] = '{6, 22, 22};

    rst_n = 1'b0; wr_valid = 1'b0; sample_tick = 1'b0; wr_band = '0; wr_gain = '0;

    // Reset held for 3 clocks, then release.
    cycles(3);
    chk("rst ready", int'(rdy_a), 0);
    chk("rst busy", int'(busy_a), 0);
    chk("rst g3", int'(g_a[3]), 0);
    rst_n = 1'b1;
    cycle();
    chk("rel ready", int'(rdy_a), 1);

    // Up-ramp band3 to +5 with STEP=1.
    write(3, 5);
    for (int n = 1; n <= 5; n++) begin
      tick();
      cycles(8);
      chk("up pre", int'(g_a[3]), n - 1);
      cycle();
      chk("up g3", int'(g_a[3]), n);
      chk("up done", int'(done_a), int'(n == 5));
      cycles(10);
    end

    // Down-ramp with clamp, STEP=4.
    do_reset();
    write(0, -100);
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n == 17) chk("down idle", int'(busy_b), 0);
      cycles(8);
      cycle();
      chk("down g0", int'(g_b[0]), (n <= 16) ? -4 * n : -64);
      chk("down done", int'(done_b), int'(n == 16));
    end

    // Stall: writes blocked during the sweep, mid-sweep tick ignored.
    do_reset();
    write(0, 3);
    tick();
    wr_valid = 1'b1; wr_band = 3'd5; wr_gain = 8'sd7;
    for (int e = 1; e <= 9; e++) begin
      chk("stall ready", int'(rdy_a), 0);
      sample_tick = (e == 4);
      cycle();
    end
    sample_tick = 1'b0;
    chk("stall ready end", int'(rdy_a), 1);
    cycle();
    wr_valid = 1'b0;
    chk("stall g0", int'(g_a[0]), 1);
    cycles(12);
    chk("stall no requeue", int'(g_a[0]), 1);
    chk("stall busy", int'(busy_a), 1);

    // Write and tick in the same idle cycle.
    do_reset();
    wr_valid = 1'b1; wr_band = 3'd7; wr_gain = 8'sd2; sample_tick = 1'b1;
    cycle();
    wr_valid = 1'b0; sample_tick = 1'b0;
    cycles(8);
    chk("simul pre", int'(g_a[7]), 0);
    cycle();
    chk("simul g7 a", int'(g_a[7]), 1);
    chk("simul g7 b", int'(g_b[7]), 2);
    chk("simul done b", int'(done_b), 1);

    // Reset in the middle of a sweep.
    do_reset();
    write(2, 10);
    tick();
    cycles(3);
    rst_n = 1'b0;
    cycle();
    chk("midrst busy", int'(busy_a), 0);
    chk("midrst ready", int'(rdy_a), 0);
    rst_n = 1'b1;
    cycle();
    chk("midrst ready rel", int'(rdy_a), 1);
    tick();
    chk("midrst no sweep", int'(busy_a), 0);

    // Clamp table on the STEP=4 instance.
    foreach (vecs[i]) begin
      do_reset();
      write(vecs[i].band, vecs[i].gain);
      for (int t = 0; t < 40 && busy_b; t++) begin
        tick();
        cycles(9);
      end
      chk("tbl settled", int'(busy_b), 0);
      chk($sformatf("tbl g[%0d] for %0d", vecs[i].band, vecs[i].gain),
          int'(g_b[vecs[i].band]), vecs[i].exp_g);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      wr_valid    = ($urandom_range(0, 2) == 0);
      wr_band     = 3'($urandom_range(0, 7));
      wr_gain     = 8'($urandom_range(0, 255));
      sample_tick = ($urandom_range(0, 7) == 0);
      cycle();
    end
    rst_n = 1'b1; wr_valid = 1'b0; sample_tick = 1'b0;
    cycles(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
